// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the multi-cycle divider in EX.
// Accepts DIV/DIVU, latches operands, drives the divider start/cancel
// handshake, stalls the pipeline while a divide is in flight and retires
// the {remainder, quotient} result as a one-cycle HI/LO write.
//
// Handshake: div_start_out is a level held from the first BUSY cycle until
// the cycle div_ready_in is seen; div_ready_in is a one-cycle pulse with
// div_res_in valid in that same cycle and is ignored outside BUSY.
// div_cancel_out is a one-cycle pulse in the cycle after a flush is seen in
// BUSY. hilo_we_out is a one-cycle pulse in DONE, killed by a same-cycle flush.
module div_ctrl #(
  parameter int REG_W = 32,
  parameter int RES_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_div_op_in,
  input  logic             ex_signed_in,
  input  logic [REG_W-1:0] ex_rs_in,
  input  logic [REG_W-1:0] ex_rt_in,
  input  logic             flush_in,
  output logic             signed_div_out,
  output logic [REG_W-1:0] dived_out,
  output logic [REG_W-1:0] div_out,
  output logic             div_start_out,
  output logic             div_cancel_out,
  input  logic [RES_W-1:0] div_res_in,
  input  logic             div_ready_in,
  output logic             stall_req_out,
  output logic             hilo_we_out,
  output logic [REG_W-1:0] hi_out,
  output logic [REG_W-1:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic req_ok;
  logic rt_zero;

  assign req_ok  = ex_div_op_in & ~flush_in;
  assign rt_zero = (ex_rt_in == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and combinational outputs; flush beats ready in BUSY.
  always_comb begin
    state_d       = state_q;
    stall_req_out = 1'b0;
    hilo_we_out   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_req_out = req_ok;
        if (req_ok) begin
          state_d = rt_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_req_out = 1'b1;
        if (flush_in) begin
          state_d = IDLE;
        end else if (div_ready_in) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Pipeline advances this cycle; a request is never accepted here.
        hilo_we_out = ~flush_in;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand latch, start/cancel handshake and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signed_div_out <= 1'b0;
      dived_out      <= '0;
      div_out        <= '0;
      div_start_out  <= 1'b0;
      div_cancel_out <= 1'b0;
      hi_out         <= '0;
      lo_out         <= '0;
    end else begin
      div_cancel_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_ok) begin
            if (rt_zero) begin
              // Divide by zero: divider untouched, architected result is 0/0.
              hi_out <= '0;
              lo_out <= '0;
            end else begin
              signed_div_out <= ex_signed_in;
              dived_out      <= ex_rs_in;
              div_out        <= ex_rt_in;
              div_start_out  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (flush_in) begin
            div_start_out  <= 1'b0;
            div_cancel_out <= 1'b1;
          end else if (div_ready_in) begin
            div_start_out <= 1'b0;
            hi_out        <= div_res_in[RES_W-1:REG_W];
            lo_out        <= div_res_in[REG_W-1:0];
          end
        end
        default: begin
          div_start_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a behavioural divider
// model and a reference built on plain signed/unsigned arithmetic.
module tb_div_ctrl;

  localparam int REG_W = 32;
  localparam int RES_W = 64;

  logic             clk;
  logic             rst_n;
  logic             ex_div_op_in;
  logic             ex_signed_in;
  logic [REG_W-1:0] ex_rs_in;
  logic [REG_W-1:0] ex_rt_in;
  logic             flush_in;
  logic             signed_div_out;
  logic [REG_W-1:0] dived_out;
  logic [REG_W-1:0] div_out;
  logic             div_start_out;
  logic             div_cancel_out;
  logic [RES_W-1:0] div_res_in;
  logic             div_ready_in;
  logic             stall_req_out;
  logic             hilo_we_out;
  logic [REG_W-1:0] hi_out;
  logic [REG_W-1:0] lo_out;

  div_ctrl #(.REG_W(REG_W), .RES_W(RES_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_div_op_in   (ex_div_op_in),
    .ex_signed_in   (ex_signed_in),
    .ex_rs_in       (ex_rs_in),
    .ex_rt_in       (ex_rt_in),
    .flush_in       (flush_in),
    .signed_div_out (signed_div_out),
    .dived_out      (dived_out),
    .div_out        (div_out),
    .div_start_out  (div_start_out),
    .div_cancel_out (div_cancel_out),
    .div_res_in     (div_res_in),
    .div_ready_in   (div_ready_in),
    .stall_req_out  (stall_req_out),
    .hilo_we_out    (hilo_we_out),
    .hi_out         (hi_out),
    .lo_out         (lo_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [RES_W-1:0] exp_q[$];
  int               exp_cancel = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: MIPS DIV/DIVU truncate toward zero; divide by zero yields 0/0.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Monitor: every HI/LO write and every cancel pulse must be expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hilo_we_out) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL hilo_unexpected: got write hi=%h lo=%h expected no write at %0t", hi_out, lo_out, $time);
        end else begin
          check("hilo_result", {hi_out, lo_out}, exp_q.pop_front());
        end
      end
      if (div_cancel_out) begin
        n_tests++;
        if (exp_cancel == 0) begin
          n_fail++;
          $display("FAIL cancel_unexpected: got cancel=1 expected 0 at %0t", $time);
        end else begin
          exp_cancel--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One EX divide. flush_at: 0 = none, 1..lat = flush in that BUSY cycle
  // (== lat means together with ready), lat+1 = flush in the DONE cycle.
  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic run_div(input logic s, input logic [31:0] rs, input logic [31:0] rt,
                         input int lat, input int flush_at);
    bit fl_busy;
    ex_div_op_in = 1'b1;
    ex_signed_in = s;
    ex_rs_in     = rs;
    ex_rt_in     = rt;
    if (flush_at == 0) exp_q.push_back(ref_div(s, rs, rt));
    @(negedge clk);
    check("c0_stall", stall_req_out, 1);
    check("c0_start", div_start_out, 0);
    if (rt == 32'd0) begin
      next_cycle();
      if (flush_at != 0) flush_in = 1'b1;
      @(negedge clk);
      check("dz_start", div_start_out, 0);
      check("dz_stall", stall_req_out, 0);
      check("dz_we", hilo_we_out, (flush_at == 0));
      next_cycle();
      flush_in     = 1'b0;
      ex_div_op_in = 1'b0;
      return;
    end
    fl_busy = (flush_at >= 1) && (flush_at <= lat);
    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      if (k == flush_at) begin
        flush_in = 1'b1;
        exp_cancel++;
      end
      if (k == lat) begin
        div_ready_in = 1'b1;
        div_res_in   = ref_div(signed_div_out, dived_out, div_out);
      end
      @(negedge clk);
      check("busy_start", div_start_out, 1);
      check("busy_stall", stall_req_out, 1);
      check("busy_we", hilo_we_out, 0);
      if (k == 1) begin
        check("op_signed", signed_div_out, s);
        check("op_dividend", dived_out, rs);
        check("op_divisor", div_out, rt);
      end
      if (k == flush_at) break;
    end
    if (fl_busy) begin
      next_cycle();
      flush_in     = 1'b0;
      div_ready_in = 1'b0;
      ex_div_op_in = 1'b0;
      @(negedge clk);
      check("cx_start", div_start_out, 0);
      check("cx_cancel", div_cancel_out, 1);
      check("cx_stall", stall_req_out, 0);
      next_cycle();
      @(negedge clk);
      check("cx_cancel_once", div_cancel_out, 0);
      // A late ready in IDLE must be ignored.
      next_cycle();
      div_ready_in = 1'b1;
      div_res_in   = {$urandom, $urandom};
      @(negedge clk);
      check("late_ready_we", hilo_we_out, 0);
      check("late_ready_start", div_start_out, 0);
      next_cycle();
      div_ready_in = 1'b0;
      return;
    end
    next_cycle();
    div_ready_in = 1'b0;
    if (flush_at == lat + 1) flush_in = 1'b1;
    @(negedge clk);
    check("done_start", div_start_out, 0);
    check("done_stall", stall_req_out, 0);
    check("done_we", hilo_we_out, (flush_at == 0));
    next_cycle();
    flush_in     = 1'b0;
    ex_div_op_in = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        s;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    int          mode;
    int          fa;

    rst_n        = 1'b0;
    ex_div_op_in = 1'b0;
    ex_signed_in = 1'b0;
    ex_rs_in     = '0;
    ex_rt_in     = '0;
    flush_in     = 1'b0;
    div_res_in   = '0;
    div_ready_in = 1'b0;
    #3;
    check("rst_start", div_start_out, 0);
    check("rst_cancel", div_cancel_out, 0);
    check("rst_we", hilo_we_out, 0);
    check("rst_stall", stall_req_out, 0);
    check("rst_hilo", {hi_out, lo_out}, 0);
    check("rst_ops", {signed_div_out, dived_out, div_out}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, 33, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 5, 0);
    run_div(1'b0, 32'd5, 32'd0, 1, 0);
    run_div(1'b0, 32'd1000, 32'd9, 33, 10);
    run_div(1'b0, 32'd77, 32'd3, 6, 6);
    run_div(1'b1, 32'd77, 32'd5, 3, 4);
    run_div(1'b0, 32'd20, 32'd3, 4, 0);
    run_div(1'b0, 32'd9, 32'd4, 1, 0);

    // Flushed request in IDLE is not accepted
    ex_div_op_in = 1'b1;
    ex_rs_in     = 32'd8;
    ex_rt_in     = 32'd2;
    flush_in     = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", stall_req_out, 0);
    next_cycle();
    @(negedge clk);
    check("idle_flush_start", div_start_out, 0);
    check("idle_flush_we", hilo_we_out, 0);
    next_cycle();
    ex_div_op_in = 1'b0;
    flush_in     = 1'b0;

    // Randomized transactions
    for (int i = 0; i < 25; i++) begin
      s  = 1'($urandom_range(0, 1));
      rs = $urandom;
      case ($urandom_range(0, 5))
        0:       rt = 32'd0;
        1, 2:    rt = $urandom;
        default: rt = $urandom_range(1, 20);
      endcase
      if (s && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd1;
      lat  = $urandom_range(1, 40);
      mode = $urandom_range(0, 4);
      case (mode)
        1:       fa = $urandom_range(1, lat);
        2:       fa = lat;
        3:       fa = lat + 1;
        default: fa = 0;
      endcase
      run_div(s, rs, rt, lat, fa);
    end

    // Reset while BUSY: everything clears immediately, nothing retires.
    ex_div_op_in = 1'b1;
    ex_signed_in = 1'b1;
    ex_rs_in     = 32'd50;
    ex_rt_in     = 32'd5;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("pre_rst_start", div_start_out, 1);
    #2;
    ex_div_op_in = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("mid_rst_start", div_start_out, 0);
    check("mid_rst_cancel", div_cancel_out, 0);
    check("mid_rst_we", hilo_we_out, 0);
    check("mid_rst_stall", stall_req_out, 0);
    check("mid_rst_hilo", {hi_out, lo_out}, 0);
    check("mid_rst_ops", {signed_div_out, dived_out, div_out}, 0);
    next_cycle();
    rst_n = 1'b1;
    div_ready_in = 1'b1;
    div_res_in   = 64'h0000_0000_0000_000A;
    next_cycle();
    div_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_start", div_start_out, 0);
      check("post_rst_we", hilo_we_out, 0);
      next_cycle();
    end

    check("sb_empty", exp_q.size(), 0);
    check("cancel_all_seen", exp_cancel, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
